// File: rtl/drive_cmd_pkg.sv
// Shared drive-code and scheduler-state definitions for the JSON drive-command sender.
package drive_cmd_pkg;

  typedef enum logic [3:0] {
    STOP     = 4'h0,
    LEFT     = 4'h1,
    RIGHT    = 4'h2,
    FWD_SLOW = 4'h3,
    FWD_MED  = 4'h4,
    FWD_FAST = 4'h5,
    REVERSE  = 4'h6,
    LREVERSE = 4'h7,
    RREVERSE = 4'h8
  } drive_code_t;

  // Anything above the last defined command is not a legal drive code.
  localparam logic [3:0] MAX_CODE = 4'(RREVERSE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/drive_cmd_scheduler_if.sv
// Request/transmit bundle between drive-code sources, the scheduler and the UART frame sender.
interface drive_cmd_scheduler_if #(
  parameter int N_REQ  = 3,
  parameter int CODE_W = 4
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*CODE_W-1:0] req_code;
  logic [N_REQ-1:0]        req_ack;
  logic                    tx_start;
  logic [CODE_W-1:0]       tx_code;
  logic                    tx_done;
  logic [CODE_W-1:0]       last_code;
  logic [15:0]             frame_count;
  logic                    timeout_flag;
  logic                    tx_fault;

  modport master (
    input  req_valid, req_code, tx_done,
    output req_ack, tx_start, tx_code, last_code, frame_count, timeout_flag, tx_fault
  );

  modport slave (
    output req_valid, req_code, tx_done,
    input  req_ack, tx_start, tx_code, last_code, frame_count, timeout_flag, tx_fault
  );
endinterface

// File: rtl/prio_arbiter.sv
// Combinational fixed-priority arbiter: lowest set request index wins, one-hot grant, zero latency.
module prio_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_any
);
  // Two's-complement trick isolates the lowest set bit.
  assign o_grant = i_req & (~i_req + N'(1));
  assign o_any   = |i_req;
endmodule

// File: rtl/drive_cmd_scheduler.sv
// Arbitrates drive-code requesters and paces one frame at a time to the UART sender (IDLE -> tx_start: 1 cycle).
// Requests are sampled only in IDLE and never queued; the sender stalls the scheduler until tx_done or timeout.
module drive_cmd_scheduler
  import drive_cmd_pkg::*;
#(
  parameter int N_REQ            = 3,
  parameter int CODE_W           = 4,
  parameter int MIN_GAP_CYCLES   = 50_000,
  parameter int HEARTBEAT_CYCLES = 25_000_000,
  parameter int TIMEOUT_CYCLES   = 50_000_000,
  parameter int DONE_TIMEOUT     = 500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  drive_cmd_scheduler_if.master bus
);

  localparam int SIL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HB_W  = $clog2(HEARTBEAT_CYCLES + 1);
  localparam int WT_W  = $clog2(DONE_TIMEOUT + 1);
  localparam int GAP_W = $clog2(MIN_GAP_CYCLES + 1);

  localparam logic [CODE_W-1:0] STOP_CODE = CODE_W'(STOP);
  localparam logic [CODE_W-1:0] SENTINEL  = {CODE_W{1'b1}};

  sched_state_t r_state, w_state_nxt;

  logic [N_REQ-1:0]  w_grant;
  logic              w_any;
  logic [CODE_W-1:0] w_win_code;
  logic [CODE_W-1:0] w_cand_raw;
  logic [CODE_W-1:0] w_cand;
  logic              w_timeout;
  logic              w_hb_expired;
  logic              w_issue;
  logic              w_tx_start;
  logic              w_fault_set;

  logic [SIL_W-1:0]  r_sil_cnt;
  logic [HB_W-1:0]   r_hb_cnt;
  logic [WT_W-1:0]   r_wait_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [CODE_W-1:0] r_tx_code;
  logic [CODE_W-1:0] r_last_sent;
  logic [CODE_W-1:0] r_last_code;
  logic [N_REQ-1:0]  r_ack_grant;
  logic [15:0]       r_frame_cnt;
  logic              r_tx_fault;

  prio_arbiter #(.N(N_REQ)) u_arb (
    .i_req   (bus.req_valid),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  always_comb begin
    w_win_code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_win_code = w_win_code | ({CODE_W{w_grant[i]}} & bus.req_code[i*CODE_W +: CODE_W]);
    end
  end

  // Silence watchdog: the flag drops combinationally the moment any request reappears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sil_cnt <= '0;
    end else if (w_any) begin
      r_sil_cnt <= '0;
    end else if (r_sil_cnt != SIL_W'(TIMEOUT_CYCLES)) begin
      r_sil_cnt <= r_sil_cnt + SIL_W'(1);
    end
  end

  assign w_timeout = !w_any && (r_sil_cnt == SIL_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hb_cnt <= '0;
    end else if (w_tx_start) begin
      r_hb_cnt <= '0;
    end else if (!w_hb_expired) begin
      r_hb_cnt <= r_hb_cnt + HB_W'(1);
    end
  end

  assign w_hb_expired = (r_hb_cnt == HB_W'(HEARTBEAT_CYCLES));

  // Sanitising the fallback too turns the post-reset sentinel into STOP, forcing a first frame.
  always_comb begin
    w_cand_raw = r_last_sent;
    if (w_timeout) begin
      w_cand_raw = STOP_CODE;
    end else if (w_any) begin
      w_cand_raw = w_win_code;
    end
  end

  assign w_cand = (w_cand_raw > CODE_W'(MAX_CODE)) ? STOP_CODE : w_cand_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_tx_start  = 1'b0;
    w_fault_set = 1'b0;
    case (r_state)
      IDLE: begin
        if ((w_cand != r_last_sent) || w_hb_expired) begin
          w_issue     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_tx_start  = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          w_state_nxt = GAP;
        end else if (r_wait_cnt == WT_W'(DONE_TIMEOUT - 1)) begin
          w_fault_set = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(MIN_GAP_CYCLES - 1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + WT_W'(1) : '0;
      r_gap_cnt  <= (r_state == GAP) ? r_gap_cnt + GAP_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_code   <= STOP_CODE;
      r_ack_grant <= '0;
      r_last_sent <= SENTINEL;
      r_last_code <= STOP_CODE;
      r_frame_cnt <= '0;
      r_tx_fault  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_tx_code   <= w_cand;
        r_ack_grant <= w_timeout ? '0 : w_grant;
      end
      if (w_tx_start) begin
        r_last_sent <= r_tx_code;
        r_last_code <= r_tx_code;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_fault_set) begin
        r_tx_fault <= 1'b1;
      end
    end
  end

  assign bus.tx_start     = w_tx_start;
  assign bus.req_ack      = w_tx_start ? r_ack_grant : '0;
  assign bus.tx_code      = r_tx_code;
  assign bus.last_code    = r_last_code;
  assign bus.frame_count  = r_frame_cnt;
  assign bus.timeout_flag = w_timeout;
  assign bus.tx_fault     = r_tx_fault;

endmodule
